// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: sequential PC generation, single-outstanding
// cache requests, and a small circular queue of {pc, inst, adel} entries
// drained by decode. Redirects flush the queue and discard in-flight data.
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ic_araddr,
    output logic        ic_arvalid,
    input  logic [31:0] ic_rdata,
    input  logic        ic_rvalid,
    output logic        ic_flush,
    output logic        deq_valid,
    input  logic        deq_ready,
    output logic [31:0] deq_pc,
    output logic [31:0] deq_inst,
    output logic        deq_adel
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        req_pc_q, req_pc_d;
    logic               stale_q, stale_d;

    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;

    logic [31:0]        ent_pc_q   [DEPTH];
    logic [31:0]        ent_pc_d   [DEPTH];
    logic [31:0]        ent_inst_q [DEPTH];
    logic [31:0]        ent_inst_d [DEPTH];
    logic               ent_adel_q [DEPTH];
    logic               ent_adel_d [DEPTH];

    logic               issue;
    logic               push;
    logic               push_en;
    logic               pop;
    logic [31:0]        push_pc;
    logic [31:0]        push_inst;
    logic               push_adel;

    // Fetch FSM: decides when to issue, what to push, and where the PC goes next.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        stale_d   = stale_q;
        issue     = 1'b0;
        push      = 1'b0;
        push_pc   = pc_q;
        push_inst = 32'd0;
        push_adel = 1'b0;
        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (count_q == FULL_CNT) begin
                    // queue full: hold the PC until decode frees a slot
                end else if (pc_q[1:0] != 2'b00) begin
                    // misaligned fetch becomes an address-error entry; fetch stops
                    push      = 1'b1;
                    push_adel = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    issue    = 1'b1;
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    stale_d = 1'b1;
                    pc_d    = redirect_pc;
                end
                if (ic_rvalid) begin
                    // a response belonging to a redirected-away stream is dropped
                    if (!(stale_q || redirect_valid)) begin
                        push      = 1'b1;
                        push_pc   = req_pc_q;
                        push_inst = ic_rdata;
                        pc_d      = req_pc_q + 32'd4;
                    end
                    stale_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // FSM and fetch PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            stale_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            stale_q  <= stale_d;
        end
    end

    assign push_en = push && !redirect_valid;
    assign pop     = (count_q != '0) && deq_ready && !redirect_valid;

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_en) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            if (push_en && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!push_en && pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Queue pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage write: the tail slot takes the pushed entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_pc_d[i]   = ent_pc_q[i];
            ent_inst_d[i] = ent_inst_q[i];
            ent_adel_d[i] = ent_adel_q[i];
        end
        if (push_en) begin
            ent_pc_d[tail_q]   = push_pc;
            ent_inst_d[tail_q] = push_inst;
            ent_adel_d[tail_q] = push_adel;
        end
    end

    // Entry registers; cleared on reset so the head outputs read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_q[i]   <= 32'd0;
                ent_inst_q[i] <= 32'd0;
                ent_adel_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_q[i]   <= ent_pc_d[i];
                ent_inst_q[i] <= ent_inst_d[i];
                ent_adel_q[i] <= ent_adel_d[i];
            end
        end
    end

    assign ic_araddr  = pc_q;
    assign ic_arvalid = issue && !rst;
    assign ic_flush   = redirect_valid;
    assign deq_valid  = (count_q != '0);
    assign deq_pc     = ent_pc_q[head_q];
    assign deq_inst   = ent_inst_q[head_q];
    assign deq_adel   = ent_adel_q[head_q];

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction-fetch front end sitting directly upstream of the instruction cache and downstream-feeding the decode stage. Generates sequential fetch PCs, issues one request at a time to the cache's slave read port, and captures returned instructions with their PCs into a small FIFO that decode drains with a valid/ready handshake. Handles branch/exception redirects by flushing the FIFO and discarding any in-flight cache response. Flags misaligned fetch addresses as an address-error entry instead of issuing them.

## Interface
- RESET_PC, 32'hBFC0_0000, fetch PC after reset
- DEPTH, 4, FIFO entries (power of two, 2..16)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- redirect_valid  in  1  redirect fetch to redirect_pc; flushes the queue
- redirect_pc  in  32  new fetch PC
- ic_araddr  out  32  cache request address (current fetch PC)
- ic_arvalid  out  1  cache request strobe, one-cycle pulse
- ic_rdata  in  32  cache returned instruction
- ic_rvalid  in  1  cache response strobe, one cycle
- ic_flush  out  1  cache flush; equals redirect_valid
- deq_valid  out  1  head entry valid
- deq_ready  in  1  decode accepts head entry
- deq_pc  out  32  head entry PC
- deq_inst  out  32  head entry instruction (0 when deq_adel)
- deq_adel  out  1  head entry is a misaligned-fetch address error

## Operation
- Cache contract: accepts a request only when idle; a response (ic_rvalid) returns 1 cycle after the request on hit, later on miss; exactly one response per accepted request; at most one outstanding.
- State machine: REQ, WAIT, HALT. Reset -> REQ, pc = RESET_PC, count = 0, stale = 0.
- REQ: if redirect_valid: pc <= redirect_pc, stay REQ, no request. Else if count == DEPTH: stall, no request. Else if pc[1:0] != 0: push {pc, inst=0, adel=1}, -> HALT, no request. Else: ic_arvalid = 1, ic_araddr = pc, latch req_pc = pc, -> WAIT.
- WAIT: redirect_valid sets stale <= 1 and pc <= redirect_pc. On ic_rvalid: if stale or redirect_valid same cycle, drop data; else push {req_pc, ic_rdata, adel=0} and pc <= req_pc + 4 (32-bit wrap, FFFF_FFFC -> 0000_0000). In both cases stale <= 0, -> REQ.
- HALT: no requests until redirect_valid; then pc <= redirect_pc, -> REQ.
- ic_arvalid is combinational: (state == REQ) && !redirect_valid && count < DEPTH && pc[1:0] == 0. ic_araddr = pc at all times.
- FIFO: circular, head/tail pointers of log2(DEPTH) bits, wrap naturally; count of log2(DEPTH)+1 bits. deq_valid = count != 0; deq_* driven from head entry registers.
- Pop when deq_valid && deq_ready. Push and pop same cycle: count unchanged. Push never overflows: issue requires count < DEPTH with no request outstanding, and pops only free space.
- Redirect: head = tail = count = 0 next cycle; suppresses any push and pop that cycle (popping outputs of that cycle are still visible to decode, which ignores them on its own redirect).

## Timing
- Reset values: ic_arvalid 0, ic_araddr RESET_PC, ic_flush 0 (follows input), deq_valid 0, deq_pc/deq_inst/deq_adel 0.
- First request in the first cycle with rst low.
- Hit path: ic_arvalid at T, ic_rvalid at T+1, entry visible on deq_* at T+2, next ic_arvalid at T+2. Peak throughput: 1 instruction / 2 cycles.
- Redirect at cycle R in REQ: request for redirect_pc at R+1. In WAIT: request for redirect_pc in the cycle after the (dropped) response.
- Misaligned entry visible on deq_* one cycle after the REQ cycle that pushed it.
- rst mid-operation: all state returns to reset values next cycle; stale cleared (cache shares rst, so no late response).

## Test plan
- Reset, all hits, deq_ready = 1: ic_araddr BFC0_0000, _0004, _0008 at cycles 0, 2, 4; deq_pc/deq_inst match in order at cycles 2, 4, 6.
- deq_ready = 0, hits: exactly 4 requests issued, ic_arvalid stays 0 with count = 4; raising deq_ready for 1 cycle allows one more request in the next cycle.
- Miss latency 12 cycles: ic_arvalid single-cycle pulse, held idle until ic_rvalid; pc advances by 4 only after response.
- redirect_valid to 8000_0100 while in WAIT: FIFO empties (deq_valid 0 next cycle); late response data dropped; next ic_araddr 8000_0100; ic_flush pulses with redirect.
- redirect_valid coincident with ic_rvalid: data dropped, next request 8000_0100 next cycle.
- redirect to 8000_0102: no cache request; entry deq_pc 8000_0102, deq_adel 1, deq_inst 0; no further requests until redirect to 8000_0200.
